// File: rtl/pdp1_panel_scan.sv
// PDP-1 style front-panel scanner: time-multiplexes three lamp rows and two
// switch rows over a shared 18-bit column bus, debouncing each switch row.
module pdp1_panel_scan #(
    parameter int unsigned DWELL    = 1000,
    parameter int unsigned BLANK    = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:17] light0,
    input  logic [0:17] light1,
    input  logic [0:17] light2,
    input  logic [0:17] col_in,
    output logic [4:0]  row_sel,
    output logic [0:17] col_out,
    output logic [0:17] sw0,
    output logic [0:17] sw1,
    output logic        frame
);

    localparam logic [15:0] TICK_LAST = 16'(DWELL - 1);
    localparam logic [15:0] TICK_SNAP = 16'(BLANK - 1);
    localparam logic [3:0]  DB_MAX    = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        ROW_L0 = 3'd0,
        ROW_L1 = 3'd1,
        ROW_L2 = 3'd2,
        ROW_S0 = 3'd3,
        ROW_S1 = 3'd4
    } row_t;

    typedef struct packed {
        logic [0:17] cand;
        logic [3:0]  cnt;
        logic        upd;
    } db_t;

    row_t        row;
    logic [15:0] tick;
    logic [0:17] cand3, cand4;
    logic [3:0]  cnt3, cnt4;
    logic [0:17] lamp_sel;
    db_t         db3_nxt, db4_nxt;
    logic        row_end, snap_now;

    function automatic row_t next_row(input row_t r);
        case (r)
            ROW_L0:  return ROW_L1;
            ROW_L1:  return ROW_L2;
            ROW_L2:  return ROW_S0;
            ROW_S0:  return ROW_S1;
            default: return ROW_L0;
        endcase
    endfunction

    function automatic logic [4:0] row_onehot(input row_t r);
        case (r)
            ROW_L0:  return 5'b00001;
            ROW_L1:  return 5'b00010;
            ROW_L2:  return 5'b00100;
            ROW_S0:  return 5'b01000;
            default: return 5'b10000;
        endcase
    endfunction

    // A fresh sample restarts the run at 1; a repeat extends it up to DB_MAX.
    // The output register follows whenever the run is at DB_MAX after the step.
    function automatic db_t db_step(input logic [0:17] cand,
                                    input logic [3:0]  cnt,
                                    input logic [0:17] smp);
        db_t r;
        r.cand = cand;
        r.cnt  = cnt;
        if (smp != cand) begin
            r.cand = smp;
            r.cnt  = 4'd1;
        end else if (cnt < DB_MAX) begin
            r.cnt = cnt + 4'd1;
        end
        r.upd = (r.cnt == DB_MAX);
        return r;
    endfunction

    always_comb begin
        lamp_sel = '0;
        case (row)
            ROW_L0:  lamp_sel = light0;
            ROW_L1:  lamp_sel = light1;
            ROW_L2:  lamp_sel = light2;
            default: lamp_sel = '0;
        endcase
    end

    assign row_end  = (tick == TICK_LAST);
    assign snap_now = (tick == TICK_SNAP) &&
                      (row == ROW_L0 || row == ROW_L1 || row == ROW_L2);
    assign db3_nxt  = db_step(cand3, cnt3, col_in);
    assign db4_nxt  = db_step(cand4, cnt4, col_in);

    // Row change and column blanking share the wrap edge so a lamp pattern
    // never overlaps a switch-row strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row     <= ROW_L0;
            tick    <= '0;
            row_sel <= 5'b00001;
            col_out <= '0;
            sw0     <= '0;
            sw1     <= '0;
            cand3   <= '0;
            cand4   <= '0;
            cnt3    <= '0;
            cnt4    <= '0;
            frame   <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (row_end) begin
                tick    <= '0;
                col_out <= '0;
                row     <= next_row(row);
                row_sel <= row_onehot(next_row(row));
                frame   <= (row == ROW_S1);
                if (row == ROW_S0) begin
                    cand3 <= db3_nxt.cand;
                    cnt3  <= db3_nxt.cnt;
                    if (db3_nxt.upd)
                        sw0 <= db3_nxt.cand;
                end
                if (row == ROW_S1) begin
                    cand4 <= db4_nxt.cand;
                    cnt4  <= db4_nxt.cnt;
                    if (db4_nxt.upd)
                        sw1 <= db4_nxt.cand;
                end
            end else begin
                tick <= tick + 16'd1;
                if (snap_now)
                    col_out <= lamp_sel;
            end
        end
    end

endmodule

// File: doc/pdp1_panel_scan.md
PDP1_PANEL_SCAN -- requirements
Module: pdp1_panel_scan

Parameters
- DWELL, default 8'd... no: DWELL, default 1000, clocks per row; legal range BLANK+2 to 65535.
- BLANK, default 16, blanked clocks at the start of each row; legal range 1 to DWELL-2.
- DEBOUNCE, default 4, consecutive identical samples required; legal range 1 to 15.

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state changes on the posedge.
REQ-002 SHALL: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: light0, light1, light2  input  18 each, bits [0:17]  lamp data for panel rows 0-2.
REQ-004 SHALL: col_in  input  18 [0:17]  switch column sense, 1 = closed.
REQ-005 SHALL: row_sel  output  5  one-hot row strobe, bit r = row r; rows 0-2 are lamp rows, rows 3-4 are switch rows.
REQ-006 SHALL: col_out  output  18 [0:17]  lamp column drive, registered.
REQ-007 SHALL: sw0, sw1  output  18 [0:17]  debounced switch rows 3 and 4, registered.
REQ-008 SHALL: frame  output  1  one-cycle pulse at the start of each full scan.

Function
REQ-009 SHALL: the tick counter counts 0..DWELL-1 and wraps to 0; the row index advances on each wrap in the order 0,1,2,3,4,0.
REQ-010 SHALL: row_sel is one-hot for the current row for the whole dwell, including the blank ticks.
REQ-011 SHALL: in lamp row r, at the edge ending tick BLANK-1, col_out loads lightr; col_out therefore shows that snapshot during ticks BLANK..DWELL-1.
REQ-012 SHALL: col_out is 0 during ticks 0..BLANK-1 of every row and during all ticks of rows 3-4.
REQ-013 SHALL: lamp input changes after the snapshot have no effect until that row's next visit.
REQ-014 SHALL: in switch rows 3 and 4, col_in is sampled only at the edge ending tick DWELL-1.
REQ-015 SHALL: each switch row keeps its own candidate register (18 bits) and match counter (4 bits).
REQ-016 SHALL: when a sample differs from the candidate, the candidate loads the sample and the counter is set to 1.
REQ-017 SHALL: when a sample equals the candidate, the counter increments and saturates at DEBOUNCE.
REQ-018 SHALL: sw0 (row 3) or sw1 (row 4) loads the candidate at the sampling edge on which the counter value becomes or stays DEBOUNCE, including the mismatch case when DEBOUNCE=1; the new value is visible on the next cycle.
REQ-019 SHALL: sw0 and sw1 never change at any edge other than their own row's sampling edge.
REQ-020 SHALL: frame is high for exactly the one cycle following the edge that wraps row 4 to row 0.
REQ-021 SHALL: no lamp row and switch row are ever driven in the same cycle; the row transition and the clearing of col_out occur on the same edge.

Reset
REQ-022 SHALL: while reset_n=0, immediately and independent of clk: row=0, tick=0, row_sel=5'b00001, col_out=0, sw0=0, sw1=0, candidates=0, counters=0, frame=0.
REQ-023 SHALL: assertion of reset_n mid-row or mid-debounce discards all progress; after release, scanning starts at row 0, tick 0.
REQ-024 SHALL: the first edge after release counts as the end of tick 0.

Verification (DWELL=8, BLANK=2, DEBOUNCE=3)
REQ-025 SHALL: hold reset_n low -> row_sel=00001, col_out=0, sw0=sw1=0, frame=0.
REQ-026 SHALL: release reset with light0=18'o252525 -> col_out=0 for ticks 0-1 and 18'o252525 for ticks 2-7; row_sel sequences 1,2,4,8,16 every 8 clocks; frame pulses once every 40 clocks.
REQ-027 SHALL: hold col_in=18'o400000 steadily -> sw0=18'o400000 after the 3rd row-3 sample, not after the 2nd; sw1 is updated likewise on row-4 samples.
REQ-028 SHALL: present col_in=18'o000001 for 2 consecutive row-3 samples, then 0 -> sw0 is never updated to 18'o000001.
REQ-029 SHALL: change light1 from 18'o777777 to 0 at tick 4 of row 1 -> col_out holds 18'o777777 through tick 7, then shows 0 on the next row-1 visit.
REQ-030 SHALL: pulse reset_n low during row 2, tick 5, with sw0 nonzero -> row_sel=00001, col_out=0, sw0=0 asynchronously; scanning restarts at row 0, tick 0.
